// File: rtl/hamming_arb_ctrl.sv
// rtl/hamming_arb_ctrl.sv - round-robin byte scheduler/sequencer for the Hamming(7,4) datapath
//
// Purpose:
//   Arbitrates between two byte requesters (A, B) and sends the granted byte
//   through an external combinational Hamming(7,4) encoder/syndrome datapath.
//   Each byte goes through as two nibbles, low nibble first. The two 7-bit
//   codes are assembled into a 14-bit word tagged with its source. Every
//   datapath cycle is checked against the returned syndrome.
//
// Ports:
//   clk, rst             - rising-edge clock, asynchronous active-high reset
//   a_valid/a_data/a_ready - requester A byte handshake (ready is combinational)
//   b_valid/b_data/b_ready - requester B byte handshake (ready is combinational)
//   dp_data              - nibble driven to datapath data_in
//   dp_code, dp_syndrome - datapath code_out and syndrome for dp_data
//   out_valid/out_ready  - codeword pair handshake toward the link framer
//   out_code             - {hi-nibble code, lo-nibble code}
//   out_src              - 0 = A, 1 = B
//   out_err              - nonzero syndrome seen on either nibble of this word
//   err_flag, err_count  - sticky fault flag and saturating fault-cycle count
//   err_clr              - synchronous clear of err_flag/err_count

module hamming_arb_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid,
  input  logic [7:0]  a_data,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [7:0]  b_data,
  output logic        b_ready,
  output logic [3:0]  dp_data,
  input  logic [6:0]  dp_code,
  input  logic [2:0]  dp_syndrome,
  output logic        out_valid,
  output logic [13:0] out_code,
  output logic        out_src,
  output logic        out_err,
  input  logic        out_ready,
  output logic        err_flag,
  output logic [7:0]  err_count,
  input  logic        err_clr
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

  state_t      state_q;
  logic [7:0]  byte_q;
  logic        src_q;
  logic [6:0]  lo_q;
  logic        word_err_q;
  logic        last_q;        // last granted requester: 0 = A, 1 = B
  logic        out_valid_q;
  logic [13:0] out_code_q;
  logic        out_src_q;
  logic        out_err_q;
  logic        err_flag_q;
  logic        err_flag_d;
  logic [7:0]  err_count_q;
  logic [7:0]  err_count_d;

  logic        grant_a;
  logic        grant_b;
  logic        in_dp_cycle;
  logic        syn_err;

  // B wins only if A is not asking, or both ask and A was served last.
  assign grant_b = b_valid && (!a_valid || !last_q);
  assign grant_a = a_valid && !grant_b;

  // Ready is only offered in IDLE, so a stalled output word blocks both sides.
  assign a_ready = (state_q == ST_IDLE) && grant_a;
  assign b_ready = (state_q == ST_IDLE) && grant_b;

  // Nibble select for the datapath; zero outside the two datapath cycles.
  always_comb begin
    dp_data = 4'h0;
    case (state_q)
      ST_LO:   dp_data = byte_q[3:0];
      ST_HI:   dp_data = byte_q[7:4];
      default: dp_data = 4'h0;
    endcase
  end

  assign in_dp_cycle = (state_q == ST_LO) || (state_q == ST_HI);
  assign syn_err     = in_dp_cycle && (dp_syndrome != 3'b000);

  // Fault bookkeeping; a clear takes priority over a coincident fault.
  always_comb begin
    err_flag_d  = err_flag_q;
    err_count_d = err_count_q;
    if (err_clr) begin
      err_flag_d  = 1'b0;
      err_count_d = 8'h00;
    end else if (syn_err) begin
      err_flag_d = 1'b1;
      if (err_count_q != 8'hFF) begin
        err_count_d = err_count_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      byte_q      <= 8'h00;
      src_q       <= 1'b0;
      lo_q        <= 7'h00;
      word_err_q  <= 1'b0;
      last_q      <= 1'b1;
      out_valid_q <= 1'b0;
      out_code_q  <= 14'h0000;
      out_src_q   <= 1'b0;
      out_err_q   <= 1'b0;
      err_flag_q  <= 1'b0;
      err_count_q <= 8'h00;
    end else begin
      err_flag_q  <= err_flag_d;
      err_count_q <= err_count_d;
      case (state_q)
        ST_IDLE: begin
          if (grant_a || grant_b) begin
            byte_q     <= grant_b ? b_data : a_data;
            src_q      <= grant_b;
            last_q     <= grant_b;
            word_err_q <= 1'b0;
            state_q    <= ST_LO;
          end
        end
        ST_LO: begin
          lo_q       <= dp_code;
          word_err_q <= (dp_syndrome != 3'b000);
          state_q    <= ST_HI;
        end
        ST_HI: begin
          // Output word is registered here so it is stable for the whole OUT phase.
          out_code_q  <= {dp_code, lo_q};
          out_src_q   <= src_q;
          out_err_q   <= word_err_q || (dp_syndrome != 3'b000);
          out_valid_q <= 1'b1;
          state_q     <= ST_OUT;
        end
        ST_OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_code  = out_code_q;
  assign out_src   = out_src_q;
  assign out_err   = out_err_q;
  assign err_flag  = err_flag_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_hamming_arb_ctrl.sv
// tb/tb_hamming_arb_ctrl.sv - directed self-checking bench for hamming_arb_ctrl

module tb_hamming_arb_ctrl;

  logic        clk;
  logic        rst;
  logic        a_valid;
  logic [7:0]  a_data;
  logic        a_ready;
  logic        b_valid;
  logic [7:0]  b_data;
  logic        b_ready;
  logic [3:0]  dp_data;
  logic [6:0]  dp_code;
  logic [2:0]  dp_syndrome;
  logic        out_valid;
  logic [13:0] out_code;
  logic        out_src;
  logic        out_err;
  logic        out_ready;
  logic        err_flag;
  logic [7:0]  err_count;
  logic        err_clr;
  logic        syn_force;

  int n_cmp;
  int n_err;

  // Stand-in for the external Hamming(7,4) encoder: {d3,d2,d1,p3,d0,p2,p1}.
  function automatic logic [6:0] ham(input logic [3:0] d);
    logic p1, p2, p3;
    p1 = d[0] ^ d[1] ^ d[3];
    p2 = d[0] ^ d[2] ^ d[3];
    p3 = d[1] ^ d[2] ^ d[3];
    return {d[3], d[2], d[1], p3, d[0], p2, p1};
  endfunction

  function automatic logic [13:0] hw(input logic [7:0] b);
    return {ham(b[7:4]), ham(b[3:0])};
  endfunction

  assign dp_code     = ham(dp_data);
  assign dp_syndrome = syn_force ? 3'b101 : 3'b000;

  hamming_arb_ctrl dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .dp_data(dp_data), .dp_code(dp_code), .dp_syndrome(dp_syndrome),
    .out_valid(out_valid), .out_code(out_code), .out_src(out_src), .out_err(out_err),
    .out_ready(out_ready),
    .err_flag(err_flag), .err_count(err_count), .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset;
    rst = 1'b1; a_valid = 1'b0; a_data = 8'h00; b_valid = 1'b0; b_data = 8'h00;
    out_ready = 1'b0; err_clr = 1'b0; syn_force = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %0h want 0", out_valid); end
    n_cmp++; if (out_code !== 14'h0) begin n_err++; $display("FAIL reset_out_code got %0h want 0", out_code); end
    n_cmp++; if (out_src !== 1'b0) begin n_err++; $display("FAIL reset_out_src got %0h want 0", out_src); end
    n_cmp++; if (out_err !== 1'b0) begin n_err++; $display("FAIL reset_out_err got %0h want 0", out_err); end
    n_cmp++; if (err_flag !== 1'b0) begin n_err++; $display("FAIL reset_err_flag got %0h want 0", err_flag); end
    n_cmp++; if (err_count !== 8'h0) begin n_err++; $display("FAIL reset_err_count got %0h want 0", err_count); end
    n_cmp++; if (dp_data !== 4'h0) begin n_err++; $display("FAIL reset_dp_data got %0h want 0", dp_data); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_a;
    @(negedge clk);
    a_valid = 1'b1; a_data = 8'h00; out_ready = 1'b0; #1;
    n_cmp++; if (a_ready !== 1'b1) begin n_err++; $display("FAIL single_a_ready got %0h want 1", a_ready); end
    @(negedge clk);   // LO
    a_valid = 1'b0; #1;
    n_cmp++; if (a_ready !== 1'b0) begin n_err++; $display("FAIL single_a_ready_drop got %0h want 0", a_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_lo_valid got %0h want 0", out_valid); end
    @(negedge clk);   // HI
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_hi_valid got %0h want 0", out_valid); end
    @(negedge clk);   // OUT
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL single_out_valid got %0h want 1", out_valid); end
    n_cmp++; if (out_code !== 14'h0000) begin n_err++; $display("FAIL single_out_code got %0h want 0", out_code); end
    n_cmp++; if (out_src !== 1'b0) begin n_err++; $display("FAIL single_out_src got %0h want 0", out_src); end
    n_cmp++; if (out_err !== 1'b0) begin n_err++; $display("FAIL single_out_err got %0h want 0", out_err); end
    out_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_release got %0h want 0", out_valid); end
  endtask

  task automatic test_b_pair;
    out_ready = 1'b1; b_valid = 1'b1; b_data = 8'hFF; #1;
    n_cmp++; if (b_ready !== 1'b1) begin n_err++; $display("FAIL bpair_ready got %0h want 1", b_ready); end
    @(negedge clk);   // LO
    b_data = 8'hF0; #1;
    n_cmp++; if (dp_data !== 4'hF) begin n_err++; $display("FAIL bpair_lo_nibble got %0h want f", dp_data); end
    n_cmp++; if (b_ready !== 1'b0) begin n_err++; $display("FAIL bpair_busy_ready got %0h want 0", b_ready); end
    @(negedge clk);   // HI
    n_cmp++; if (dp_data !== 4'hF) begin n_err++; $display("FAIL bpair_hi_nibble got %0h want f", dp_data); end
    @(negedge clk);   // OUT
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bpair_valid1 got %0h want 1", out_valid); end
    n_cmp++; if (out_code !== 14'h3FFF) begin n_err++; $display("FAIL bpair_code1 got %0h want 3fff", out_code); end
    n_cmp++; if (out_src !== 1'b1) begin n_err++; $display("FAIL bpair_src1 got %0h want 1", out_src); end
    @(negedge clk);   // IDLE
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bpair_gap got %0h want 0", out_valid); end
    n_cmp++; if (b_ready !== 1'b1) begin n_err++; $display("FAIL bpair_ready2 got %0h want 1", b_ready); end
    @(negedge clk);   // LO
    b_valid = 1'b0;
    @(negedge clk);   // HI
    @(negedge clk);   // OUT, 4 cycles after the first word
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bpair_valid2 got %0h want 1", out_valid); end
    n_cmp++; if (out_code !== 14'h3F80) begin n_err++; $display("FAIL bpair_code2 got %0h want 3f80", out_code); end
    n_cmp++; if (out_src !== 1'b1) begin n_err++; $display("FAIL bpair_src2 got %0h want 1", out_src); end
    @(negedge clk);
  endtask

  task automatic test_alternate;
    logic [7:0] av [4];
    logic [7:0] bv [4];
    logic [7:0] eb;
    int ai, bi, k;
    av = '{8'h11, 8'h22, 8'h33, 8'h44};
    bv = '{8'h55, 8'h66, 8'h77, 8'h88};
    ai = 0; bi = 0; k = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 60 && k < 8; c++) begin
      a_valid = (ai < 4); a_data = (ai < 4) ? av[ai] : 8'h00;
      b_valid = (bi < 4); b_data = (bi < 4) ? bv[bi] : 8'h00;
      #1;
      if (out_valid) begin
        eb = (k % 2 == 0) ? av[k/2] : bv[k/2];
        n_cmp++; if (out_src !== ((k % 2) == 1)) begin n_err++; $display("FAIL alt_src word %0d got %0h want %0h", k, out_src, (k % 2)); end
        n_cmp++; if (out_code !== hw(eb)) begin n_err++; $display("FAIL alt_code word %0d got %0h want %0h", k, out_code, hw(eb)); end
        k++;
      end
      if (a_ready) ai++;
      if (b_ready) bi++;
      @(negedge clk);
    end
    a_valid = 1'b0; b_valid = 1'b0;
    n_cmp++; if (k != 8) begin n_err++; $display("FAIL alt_word_count got %0d want 8", k); end
    n_cmp++; if (ai != 4 || bi != 4) begin n_err++; $display("FAIL alt_grants got a=%0d b=%0d want 4 4", ai, bi); end
  endtask

  task automatic test_stall;
    a_valid = 1'b1; a_data = 8'h5A; b_valid = 1'b1; b_data = 8'hC3; out_ready = 1'b0; #1;
    n_cmp++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin n_err++; $display("FAIL stall_grant got a=%0h b=%0h want a=1 b=0", a_ready, b_ready); end
    @(negedge clk);
    a_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);   // OUT
    for (int i = 0; i < 10; i++) begin
      #1;
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid cyc %0d got %0h want 1", i, out_valid); end
      n_cmp++; if (out_code !== hw(8'h5A)) begin n_err++; $display("FAIL stall_code cyc %0d got %0h want %0h", i, out_code, hw(8'h5A)); end
      n_cmp++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin n_err++; $display("FAIL stall_ready cyc %0d got a=%0h b=%0h want 0 0", i, a_ready, b_ready); end
      @(negedge clk);
    end
    out_ready = 1'b1; a_valid = 1'b1;
    @(negedge clk);   // IDLE: both valid, A was last so B wins
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stall_release got %0h want 0", out_valid); end
    n_cmp++; if (b_ready !== 1'b1 || a_ready !== 1'b0) begin n_err++; $display("FAIL stall_next_grant got a=%0h b=%0h want a=0 b=1", a_ready, b_ready); end
    @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1 || out_src !== 1'b1 || out_code !== hw(8'hC3)) begin
      n_err++; $display("FAIL stall_b_word got v=%0h s=%0h c=%0h want 1 1 %0h", out_valid, out_src, out_code, hw(8'hC3));
    end
    @(negedge clk);
  endtask

  task automatic test_err_single;
    out_ready = 1'b1; a_valid = 1'b1; a_data = 8'h3C;
    @(negedge clk);   // LO
    a_valid = 1'b0;
    @(negedge clk);   // HI
    syn_force = 1'b1;
    @(negedge clk);   // OUT
    syn_force = 1'b0; #1;
    n_cmp++; if (out_err !== 1'b1) begin n_err++; $display("FAIL err1_out_err got %0h want 1", out_err); end
    n_cmp++; if (err_flag !== 1'b1) begin n_err++; $display("FAIL err1_flag got %0h want 1", err_flag); end
    n_cmp++; if (err_count !== 8'd1) begin n_err++; $display("FAIL err1_count got %0d want 1", err_count); end
    n_cmp++; if (out_code !== hw(8'h3C)) begin n_err++; $display("FAIL err1_code got %0h want %0h", out_code, hw(8'h3C)); end
    @(negedge clk);
  endtask

  task automatic test_err_saturate;
    out_ready = 1'b1; a_valid = 1'b1; a_data = 8'h81; syn_force = 1'b1;
    repeat (620) @(negedge clk);
    a_valid = 1'b0;
    repeat (8) @(negedge clk);
    syn_force = 1'b0; #1;
    n_cmp++; if (err_count !== 8'd255) begin n_err++; $display("FAIL sat_count got %0d want 255", err_count); end
    n_cmp++; if (err_flag !== 1'b1) begin n_err++; $display("FAIL sat_flag got %0h want 1", err_flag); end
  endtask

  task automatic test_err_clr;
    out_ready = 1'b1; a_valid = 1'b1; a_data = 8'h96;
    @(negedge clk);   // LO
    a_valid = 1'b0;
    @(negedge clk);   // HI
    syn_force = 1'b1; err_clr = 1'b1;
    @(negedge clk);   // OUT
    syn_force = 1'b0; err_clr = 1'b0; #1;
    n_cmp++; if (err_count !== 8'd0) begin n_err++; $display("FAIL clr_count got %0d want 0", err_count); end
    n_cmp++; if (err_flag !== 1'b0) begin n_err++; $display("FAIL clr_flag got %0h want 0", err_flag); end
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL clr_word_valid got %0h want 1", out_valid); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b1; a_valid = 1'b1; a_data = 8'h12; b_valid = 1'b1; b_data = 8'h34; #1;
    n_cmp++; if (b_ready !== 1'b1 || a_ready !== 1'b0) begin n_err++; $display("FAIL mid_pre_grant got a=%0h b=%0h want a=0 b=1", a_ready, b_ready); end
    @(negedge clk);   // LO
    a_valid = 1'b0; b_valid = 1'b0;
    @(negedge clk);   // HI
    #1;
    n_cmp++; if (dp_data !== 4'h3) begin n_err++; $display("FAIL mid_hi_nibble got %0h want 3", dp_data); end
    rst = 1'b1; #1;
    n_cmp++; if (dp_data !== 4'h0) begin n_err++; $display("FAIL mid_dp_data got %0h want 0", dp_data); end
    n_cmp++; if (out_valid !== 1'b0 || out_code !== 14'h0 || out_src !== 1'b0 || out_err !== 1'b0) begin
      n_err++; $display("FAIL mid_outputs got v=%0h c=%0h s=%0h e=%0h want all 0", out_valid, out_code, out_src, out_err);
    end
    n_cmp++; if (err_flag !== 1'b0 || err_count !== 8'h0) begin n_err++; $display("FAIL mid_err got f=%0h c=%0h want 0 0", err_flag, err_count); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_no_output cyc %0d got %0h want 0", i, out_valid); end
    end
    a_valid = 1'b1; a_data = 8'h12; b_valid = 1'b1; b_data = 8'h34; #1;
    n_cmp++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin n_err++; $display("FAIL mid_post_grant got a=%0h b=%0h want a=1 b=0", a_ready, b_ready); end
    @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1 || out_src !== 1'b0 || out_code !== hw(8'h12)) begin
      n_err++; $display("FAIL mid_a_word got v=%0h s=%0h c=%0h want 1 0 %0h", out_valid, out_src, out_code, hw(8'h12));
    end
    @(negedge clk);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_single_a();
    test_b_pair();
    test_alternate();
    test_stall();
    test_err_single();
    test_err_saturate();
    test_err_clr();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
